// File: rtl/pixel_frame_loader.sv
// Parses a command byte plus WIDTH*HEIGHT pixel bytes from the SPI byte stream into frame-buffer writes.
// Define FRAME_CHECKSUM_EN to require a trailing XOR checksum byte (adds CHECK state and errChecksum).
module pixel_frame_loader #(
    parameter int          WIDTH     = 64,
    parameter int          HEIGHT    = 48,
    parameter int          ADDR_W    = 12,
    parameter logic [7:0]  CMD_WRITE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              writeEnable,
    input  logic [7:0]        writeData,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [7:0]        memData,
    output logic              frameDone,
    output logic              busy,
    output logic              errShort,
    output logic              errOverrun,
`ifdef FRAME_CHECKSUM_EN
    output logic              errChecksum,
`endif
    output logic              errCmd
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_PIXELS = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;

    localparam int unsigned        NPIX      = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NPIX - 1);

    logic [2:0]        state_q, state_d, state_mid;
    logic              cs_q;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [7:0]        memData_q, memData_d;
    logic              done_q, done_d;
    logic              busy_q;
    logic              errShort_q, errShort_d;
    logic              errOverrun_q, errOverrun_d;
    logic              errCmd_q, errCmd_d;
    logic              complete_q, complete_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              errCsum_q, errCsum_d;
`endif

    always_comb begin
        state_mid    = state_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        memWe_d      = 1'b0;
        memAddr_d    = memAddr_q;
        memData_d    = memData_q;
        done_d       = 1'b0;
        errShort_d   = errShort_q;
        errOverrun_d = errOverrun_q;
        errCmd_d     = errCmd_q;
        complete_d   = complete_q;
`ifdef FRAME_CHECKSUM_EN
        csum_d       = csum_q;
        errCsum_d    = errCsum_q;
`endif
        // The incoming byte is consumed first; the cs-low check below then acts on the resulting state.
        case (state_q)
            S_IDLE: begin
                if (cs && !cs_q) begin
                    state_mid  = S_CMD;
                    complete_d = 1'b0;
                end
            end
            S_CMD: begin
                if (writeEnable) begin
                    if (writeData == CMD_WRITE) begin
                        state_mid = S_PIXELS;
                        cnt_d     = '0;
`ifdef FRAME_CHECKSUM_EN
                        csum_d    = 8'h00;
`endif
                    end else begin
                        errCmd_d  = 1'b1;
                        state_mid = S_DRAIN;
                    end
                end
            end
            S_PIXELS: begin
                if (writeEnable) begin
                    memWe_d   = 1'b1;
                    memAddr_d = cnt_q;
                    memData_d = writeData;
                    cnt_d     = cnt_q + ADDR_W'(1);
`ifdef FRAME_CHECKSUM_EN
                    csum_d    = csum_q ^ writeData;
                    if (cnt_q == LAST_ADDR) begin
                        state_mid = S_CHECK;
                    end
`else
                    if (cnt_q == LAST_ADDR) begin
                        done_d     = 1'b1;
                        complete_d = 1'b1;
                        state_mid  = S_DRAIN;
                    end
`endif
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CHECK: begin
                if (writeEnable) begin
                    if (writeData == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        errCsum_d = 1'b1;
                    end
                    complete_d = 1'b1;
                    state_mid  = S_DRAIN;
                end
            end
`endif
            S_DRAIN: begin
                if (writeEnable && complete_q) begin
                    errOverrun_d = 1'b1;
                end
            end
            default: state_mid = S_IDLE;
        endcase

        state_d = state_mid;
        if (!cs && (state_mid != S_IDLE)) begin
            state_d = S_IDLE;
            if ((state_mid == S_PIXELS) || (state_mid == S_CHECK)) begin
                errShort_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cs_q         <= 1'b0;
            cnt_q        <= '0;
            memWe_q      <= 1'b0;
            memAddr_q    <= '0;
            memData_q    <= 8'h00;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            errShort_q   <= 1'b0;
            errOverrun_q <= 1'b0;
            errCmd_q     <= 1'b0;
            complete_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= 8'h00;
            errCsum_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cs_q         <= cs;
            cnt_q        <= cnt_d;
            memWe_q      <= memWe_d;
            memAddr_q    <= memAddr_d;
            memData_q    <= memData_d;
            done_q       <= done_d;
            busy_q       <= (state_d == S_CMD) || (state_d == S_PIXELS);
            errShort_q   <= errShort_d;
            errOverrun_q <= errOverrun_d;
            errCmd_q     <= errCmd_d;
            complete_q   <= complete_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= csum_d;
            errCsum_q    <= errCsum_d;
`endif
        end
    end

    assign memWe      = memWe_q;
    assign memAddr    = memAddr_q;
    assign memData    = memData_q;
    assign frameDone  = done_q;
    assign busy       = busy_q;
    assign errShort   = errShort_q;
    assign errOverrun = errOverrun_q;
    assign errCmd     = errCmd_q;
`ifdef FRAME_CHECKSUM_EN
    assign errChecksum = errCsum_q;
`endif

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Scoreboard bench for pixel_frame_loader: stimulus queues expected writes, a negedge monitor checks them.
module tb_pixel_frame_loader;

    localparam int         ADDR_W = 12;
    localparam int         NPIX   = 64 * 48;
`ifdef FRAME_CHECKSUM_EN
    localparam bit         CSUM   = 1'b1;
`else
    localparam bit         CSUM   = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cs = 1'b0;
    logic              writeEnable = 1'b0;
    logic [7:0]        writeData = 8'h00;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [7:0]        memData;
    logic              frameDone;
    logic              busy;
    logic              errShort;
    logic              errOverrun;
    logic              errCmd;
`ifdef FRAME_CHECKSUM_EN
    logic              errChecksum;
    logic [7:0]        csum_flip = 8'h00;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              done;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   nwr    = 0;
    int   ndone  = 0;

    pixel_frame_loader #(
        .WIDTH(64), .HEIGHT(48), .ADDR_W(ADDR_W), .CMD_WRITE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs),
        .writeEnable(writeEnable), .writeData(writeData),
        .memWe(memWe), .memAddr(memAddr), .memData(memData),
        .frameDone(frameDone), .busy(busy),
        .errShort(errShort), .errOverrun(errOverrun),
`ifdef FRAME_CHECKSUM_EN
        .errChecksum(errChecksum),
`endif
        .errCmd(errCmd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every memWe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (memWe === 1'b1) begin
            exp_t e;
            nwr++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: actual addr=%0d required no write", memAddr);
            end else begin
                e = expq.pop_front();
                check("wr_addr", 32'(memAddr), 32'(e.addr));
                check("wr_data", 32'(memData), 32'(e.data));
                check("wr_done", 32'(frameDone), 32'(e.done));
            end
        end
        if (frameDone === 1'b1) ndone++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn();
        cs = 1'b1;
        tick();
    endtask

    task automatic end_txn();
        writeEnable = 1'b0;
        cs = 1'b0;
        tick();
        tick();
    endtask

    task automatic drive_byte(input logic [7:0] b);
        writeEnable = 1'b1;
        writeData   = b;
        tick();
    endtask

    task automatic push_pixel(input int i, input logic [7:0] b, input logic done);
        exp_t e;
        e.addr = ADDR_W'(i);
        e.data = b;
        e.done = done;
        expq.push_back(e);
    endtask

    // kind 0: pixel i = i mod 256; kind 1: all 0x01.
    task automatic send_frame(input int kind, input int extra, input bit drop_last);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        start_txn();
        drive_byte(8'hA5);
        for (int i = 0; i < NPIX; i++) begin
            b = (kind == 0) ? 8'(i % 256) : 8'h01;
            x = x ^ b;
            push_pixel(i, b, (i == NPIX - 1) && !CSUM);
            if (drop_last && (i == NPIX - 1) && !CSUM) cs = 1'b0;
            drive_byte(b);
        end
`ifdef FRAME_CHECKSUM_EN
        if (drop_last) cs = 1'b0;
        drive_byte(x ^ csum_flip);
`endif
        for (int k = 0; k < extra; k++) drive_byte(8'hEE);
        end_txn();
    endtask

    task automatic send_partial(input int n);
        start_txn();
        drive_byte(8'hA5);
        for (int i = 0; i < n; i++) begin
            push_pixel(i, 8'(i % 256), 1'b0);
            drive_byte(8'(i % 256));
        end
        writeEnable = 1'b0;
    endtask

    task automatic check_errs(input string tag, input logic s, input logic o, input logic c);
        check({tag, "_errShort"}, 32'(errShort), 32'(s));
        check({tag, "_errOverrun"}, 32'(errOverrun), 32'(o));
        check({tag, "_errCmd"}, 32'(errCmd), 32'(c));
    endtask

    initial begin
        int wr0;
        int dn0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_memWe", 32'(memWe), 0);
        check("rst_memAddr", 32'(memAddr), 0);
        check("rst_frameDone", 32'(frameDone), 0);
        check("rst_busy", 32'(busy), 0);
        check_errs("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Full frame, ramp pattern.
        send_frame(0, 0, 1'b0);
        check("f1_writes", 32'(nwr), NPIX);
        check("f1_done", 32'(ndone), 1);
        check("f1_busy", 32'(busy), 0);
        check_errs("f1", 1'b0, 1'b0, 1'b0);

        // cs falls together with the final byte: accepted, no short error.
        wr0 = nwr; dn0 = ndone;
        send_frame(0, 0, 1'b1);
        check("drop_writes", 32'(nwr - wr0), NPIX);
        check("drop_done", 32'(ndone - dn0), 1);
        check_errs("drop", 1'b0, 1'b0, 1'b0);

        // Bad command byte.
        wr0 = nwr;
        start_txn();
        check("cmd_busy_hi", 32'(busy), 1);
        drive_byte(8'h3C);
        check("cmd_busy_lo", 32'(busy), 0);
        check("cmd_errCmd", 32'(errCmd), 1);
        for (int k = 0; k < 10; k++) drive_byte(8'(k));
        end_txn();
        check("cmd_writes", 32'(nwr - wr0), 0);
        check_errs("cmd", 1'b0, 1'b0, 1'b1);

        // Short frame, then a good frame.
        wr0 = nwr; dn0 = ndone;
        send_partial(100);
        end_txn();
        check("short_writes", 32'(nwr - wr0), 100);
        check("short_done", 32'(ndone - dn0), 0);
        check_errs("short", 1'b1, 1'b0, 1'b1);
        wr0 = nwr;
        send_frame(0, 0, 1'b0);
        check("after_short_writes", 32'(nwr - wr0), NPIX);
        check("after_short_done", 32'(ndone - dn0), 1);

        // Overrun: two trailing bytes.
        wr0 = nwr; dn0 = ndone;
        send_frame(0, 2, 1'b0);
        check("ovr_writes", 32'(nwr - wr0), NPIX);
        check("ovr_done", 32'(ndone - dn0), 1);
        check_errs("ovr", 1'b1, 1'b1, 1'b1);

        // Reset after 500 pixels.
        wr0 = nwr;
        send_partial(500);
        rst = 1'b1;
        tick();
        check("mid_rst_memWe", 32'(memWe), 0);
        check("mid_rst_memAddr", 32'(memAddr), 0);
        check("mid_rst_memData", 32'(memData), 0);
        check("mid_rst_frameDone", 32'(frameDone), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check_errs("mid_rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cs = 1'b0;
        repeat (5) tick();
        check("mid_rst_writes", 32'(nwr - wr0), 500);
        check("mid_rst_queue", 32'(expq.size()), 0);
        wr0 = nwr; dn0 = ndone;
        send_frame(0, 0, 1'b0);
        check("post_rst_writes", 32'(nwr - wr0), NPIX);
        check("post_rst_done", 32'(ndone - dn0), 1);
        check_errs("post_rst", 1'b0, 1'b0, 1'b0);

`ifdef FRAME_CHECKSUM_EN
        dn0 = ndone;
        csum_flip = 8'h00;
        send_frame(1, 0, 1'b0);
        check("csum_ok_done", 32'(ndone - dn0), 1);
        check("csum_ok_err", 32'(errChecksum), 0);
        dn0 = ndone;
        csum_flip = 8'h01;
        send_frame(1, 0, 1'b0);
        check("csum_bad_done", 32'(ndone - dn0), 0);
        check("csum_bad_err", 32'(errChecksum), 1);
        check("csum_short", 32'(errShort), 0);
`endif

        tick();
        check("final_queue", 32'(expq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
- Sits directly downstream of the SPI byte receiver.
- Consumes the received byte stream (write-enable pulse plus 8-bit data) and parses one command byte, then WIDTH*HEIGHT grayscale pixel bytes.
- Issues sequential writes into the frame buffer RAM that feeds the edge-detection core.
- Flags frame completion and protocol errors (short frame, overrun, bad command) to the control logic.

Parameters:
- WIDTH, 64, pixels per row
- HEIGHT, 48, rows per frame
- ADDR_W, 12, frame-buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- CMD_WRITE, 8'hA5, command byte that opens a frame write

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cs  in  1  SPI transaction-active level (high = active), already synchronised to clk
- writeEnable  in  1  one-cycle pulse: writeData holds a new byte
- writeData  in  8  received byte
- memWe  out  1  frame-buffer write strobe
- memAddr  out  ADDR_W  frame-buffer write address
- memData  out  8  pixel value to write
- frameDone  out  1  one-cycle pulse: full frame written
- busy  out  1  high while in CMD or PIXELS
- errShort  out  1  sticky: cs fell before frame complete
- errOverrun  out  1  sticky: bytes received after frame complete in same transaction
- errCmd  out  1  sticky: first byte of a transaction was not CMD_WRITE

Behaviour:
- Reset (rst high at a rising edge): all outputs 0, state IDLE, pixel counter 0. Applies mid-frame too. Any partial frame is abandoned with no further writes. Sticky errors are cleared only by rst.
- States: IDLE, CMD, PIXELS, DRAIN.
- IDLE: rising edge of cs (cs=1, previous cs=0) -> CMD.
- CMD:
  - writeEnable and writeData==CMD_WRITE -> PIXELS, pixel counter 0.
  - writeEnable and any other value -> set errCmd, go to DRAIN.
  - cs low -> IDLE; no error.
- PIXELS, on each writeEnable:
  - register memWe=1, memAddr=counter, memData=writeData on the next edge. Latency is 1 cycle; memWe is a 1-cycle pulse.
  - counter increments.
  - When the write for address WIDTH*HEIGHT-1 issues, frameDone pulses in the same cycle as that memWe. Then go to DRAIN.
- PIXELS, cs falls before the last pixel: set errShort, go to IDLE. No frameDone. RAM contents past the last written address are undefined.
- DRAIN: any writeEnable sets errOverrun only if the frame completed in this transaction; after a bad command it is ignored. cs low -> IDLE.
- Simultaneous writeEnable and cs falling in the same cycle: the byte is accepted first, then the cs-low transition applies. If that byte is the final pixel, frameDone pulses and no errShort is raised.
- Counter is ADDR_W bits. Address runs linearly 0..WIDTH*HEIGHT-1 in row-major order and never wraps inside a frame.
- busy = (state==CMD)||(state==PIXELS), registered.
- memWe is never asserted outside PIXELS.
- Back-to-back writeEnable on consecutive cycles is supported at full rate.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- With the macro defined:
  - after the final pixel, the FSM enters a CHECK state awaiting one extra byte.
  - That byte must equal the XOR of all pixel bytes.
  - Match -> frameDone pulses one cycle after that byte arrives.
  - Mismatch -> new sticky output errChecksum set, no frameDone.
  - cs falling in CHECK sets errShort.
  - The last pixel's memWe no longer coincides with frameDone.
- Without the macro: no CHECK state, no errChecksum port. frameDone timing as above.

Test Plan:
- Reset, then cs high, bytes A5 followed by 3072 bytes value (i mod 256) -> 3072 memWe pulses, memAddr 0..3071, memData==i mod 256, frameDone exactly once coinciding with addr 3071, no error flags.
- cs high, byte 3C, then 10 bytes, cs low -> errCmd=1, zero memWe pulses, busy falls after the first byte.
- cs high, A5 plus 100 pixels, cs low -> 100 writes (addr 0..99), errShort=1, frameDone never pulses, next valid frame still completes normally.
- Full frame then 2 extra bytes before cs falls -> errOverrun=1, still exactly 3072 writes.
- rst pulsed after 500 pixels -> outputs 0 next cycle, no further writes; new frame after rst writes from address 0.
- FRAME_CHECKSUM_EN: full frame of all 0x01 (XOR=0x00), trailing byte 00 -> frameDone; repeat with trailing 01 -> errChecksum=1, no frameDone.
